fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter placed on the write-clock side of `async_fifo_sv`. It shares the single FIFO write port (`data_in`/`wr_en`/`full`) among `NUM_REQ` producers using valid/ready handshakes. Grants are burst-based, with a per-grant beat limit and an idle-release timeout. Back-pressure from `full` is honoured with zero slip: no write is ever issued while `full` is high.

---
 rtl/fifo_arb_pkg.sv | 45 ++++
 rtl/rr_pointer_arb.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types, width constants and the round-robin pick function used by the
// FIFO write-port arbiter (and intended for a future read-side arbiter).
//   arb_state_t : arbiter FSM state (IDLE: no grant, XFER: grant held)
//   rr_pick_t   : result of a round-robin search {found, idx}
//   rr_pick()   : first set bit of valid searching upward from last+1, wrapping
package fifo_arb_pkg;

    typedef enum logic [0:0] {IDLE, XFER} arb_state_t;

    // Widths are sized for the largest legal configuration so one package
    // serves every instance.
    localparam int unsigned MaxReq         = 8;
    localparam int unsigned ReqIdxW        = $clog2(MaxReq);
    localparam int unsigned MaxBurstLimit  = 16;
    localparam int unsigned BurstCntW      = $clog2(MaxBurstLimit + 1);
    localparam int unsigned MaxHoldTimeout = 255;
    localparam int unsigned IdleCntW       = $clog2(MaxHoldTimeout + 1);

    typedef struct packed {
        logic               found;
        logic [ReqIdxW-1:0] idx;
    } rr_pick_t;

    // Only the low num_req bits of valid are considered; candidates are visited
    // in order last+1, last+2, ... modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  valid,
                                         input logic [ReqIdxW-1:0] last,
                                         input int unsigned        num_req);
        rr_pick_t           res;
        int unsigned        cand;
        logic [ReqIdxW-1:0] cand_idx;
        res = '0;
        for (int unsigned k = 1; k <= MaxReq; k++) begin
            cand     = (32'(last) + k) % num_req;
            cand_idx = cand[ReqIdxW-1:0];
            if ((k <= num_req) && !res.found && valid[cand_idx]) begin
                res.found = 1'b1;
                res.idx   = cand_idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pointer_arb.sv
// rr_pointer_arb
// Combinational round-robin priority pick relative to a pointer.
//   req_i   : request vector
//   last_i  : index granted most recently; search starts at last_i+1
//   found_o : at least one request is set
//   idx_o   : winning index (meaningful only when found_o is high)
module rr_pointer_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic              found_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [MaxReq-1:0] req_ext;
    rr_pick_t          pick;

    always_comb begin
        req_ext               = '0;
        req_ext[NumReq-1:0]   = req_i;
        pick                  = rr_pick(req_ext, ReqIdxW'(last_i), NumReq);
        found_o               = pick.found;
        idx_o                 = IdxW'(pick.idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ
// valid/ready producers. Grants are bursts of at most MAX_BURST beats, released
// early on req_last or after HOLD_TIMEOUT consecutive idle cycles of the holder.
//   wr_clk, wr_rst_n : FIFO write clock, async active-low reset
//   req_valid/req_data/req_last/req_ready : per-requester handshake
//   fifo_full, fifo_data_in, fifo_wr_en   : FIFO write port
//   grant_valid, grant_id                 : current (or last) grant
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned HOLD_TIMEOUT = 8
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [IdxW-1:0]      grant_id_q, grant_id_d;
    logic [IdxW-1:0]      last_grant_q, last_grant_d;
    logic [BurstCntW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IdleCntW-1:0]  idle_cnt_q, idle_cnt_d;

    logic                 pick_found;
    logic [IdxW-1:0]      pick_idx;
    logic                 in_xfer;
    logic                 gnt_req_valid;
    logic                 beat_accept;
    logic [BurstCntW-1:0] burst_next;
    logic [IdleCntW-1:0]  idle_next;

    rr_pointer_arb #(
        .NumReq (NUM_REQ),
        .IdxW   (IdxW)
    ) u_rr_pointer_arb (
        .req_i   (req_valid),
        .last_i  (last_grant_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Write path is purely combinational from fifo_full so a full FIFO never
    // sees a write on the same edge.
    always_comb begin
        in_xfer       = (state_q == XFER);
        gnt_req_valid = req_valid[grant_id_q];
        beat_accept   = in_xfer && gnt_req_valid && !fifo_full;

        req_ready = '0;
        if (in_xfer && !fifo_full) begin
            req_ready[grant_id_q] = 1'b1;
        end
        fifo_wr_en   = beat_accept;
        fifo_data_in = in_xfer ? req_data[DATA_WIDTH*32'(grant_id_q) +: DATA_WIDTH] : '0;
        grant_valid  = in_xfer;
        grant_id     = grant_id_q;
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        burst_next   = burst_cnt_q + BurstCntW'(1);
        idle_next    = idle_cnt_q + IdleCntW'(1);

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = XFER;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            XFER: begin
                if (beat_accept) begin
                    burst_cnt_d = burst_next;
                    idle_cnt_d  = '0;
                    // req_last on the MAX_BURST-th beat is still one release.
                    if (req_last[grant_id_q] || (burst_next == BurstCntW'(MAX_BURST))) begin
                        state_d      = IDLE;
                        last_grant_d = grant_id_q;
                    end
                end else if (gnt_req_valid) begin
                    // Stalled by fifo_full: the holder is not idle.
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_next;
                    if (idle_next == IdleCntW'(HOLD_TIMEOUT)) begin
                        state_d      = IDLE;
                        last_grant_d = grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Scenario tasks drive per-requester beat queues; expected writes are queued
// when stimulus is loaded and compared as the arbiter writes them.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int HT = 8;
    localparam int FIFO_DEPTH = 16;

    logic              wr_clk = 1'b0;
    logic              wr_rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic [DW-1:0]     fifo_data_in;
    logic              fifo_wr_en;
    logic              grant_valid;
    logic [1:0]        grant_id;

    fifo_wr_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .MAX_BURST    (MB),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst_n     (wr_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_data_in (fifo_data_in),
        .fifo_wr_en   (fifo_wr_en),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    beat_t         prod_q[NR][$];
    logic [DW-1:0] exp_rq[NR][$];
    wr_t           exp_q[$];
    wr_t           obs_q[$];
    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] rd_q[$];

    logic [NR-1:0] en;
    bit            model_en;
    bit            force_full;
    int            cyc;
    int            errors = 0;
    int            checks = 0;

    logic          s_gv, s_wr, s_full;
    logic [1:0]    s_gid;
    logic [NR-1:0] s_ready;
    logic [DW-1:0] s_data;

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (en[i] && prod_q[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = prod_q[i][0].data;
                req_last[i]           = prod_q[i][0].last;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = DW'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
        fifo_full = model_en ? (fifo_mem.size() >= FIFO_DEPTH) : force_full;
    endtask

    // One cycle: sample at negedge, then apply handshakes after the posedge.
    task automatic tick();
        logic [NR-1:0] hs;
        wr_t           w;
        @(negedge wr_clk);
        s_gv    = grant_valid;
        s_gid   = grant_id;
        s_ready = req_ready;
        s_wr    = fifo_wr_en;
        s_data  = fifo_data_in;
        s_full  = fifo_full;
        hs      = req_valid & req_ready;
        if (fifo_wr_en) begin
            w.id   = int'(grant_id);
            w.data = fifo_data_in;
            w.cyc  = cyc;
            obs_q.push_back(w);
            if (model_en) fifo_mem.push_back(fifo_data_in);
        end
        @(posedge wr_clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (hs[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        end
        if (model_en && (cyc % 3 == 0) && fifo_mem.size() > 0) rd_q.push_back(fifo_mem.pop_front());
        drive();
    endtask

    task automatic apply_reset();
        wr_rst_n   = 1'b0;
        en         = '0;
        model_en   = 1'b0;
        force_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            prod_q[i].delete();
            exp_rq[i].delete();
        end
        exp_q.delete();
        obs_q.delete();
        fifo_mem.delete();
        rd_q.delete();
        drive();
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        @(posedge wr_clk);
        #1;
        cyc = 0;
    endtask

    task automatic push_beat(input int id, input int data, input bit last);
        beat_t b;
        wr_t   e;
        b.data = DW'(data);
        b.last = last;
        prod_q[id].push_back(b);
        e.id   = id;
        e.data = DW'(data);
        e.cyc  = 0;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        en = '0; model_en = 1'b0; force_full = 1'b0;
        wr_rst_n = 1'b1;
        drive();
        #1 wr_rst_n = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_gv: got %b want 0", grant_valid); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); end
        checks++; if (fifo_data_in !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", fifo_data_in); end
        apply_reset();
        tick();
        checks++; if (s_gv !== 1'b0 || s_wr !== 1'b0 || s_ready !== 4'b0 || s_data !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_rst: got gv=%b wr=%b rdy=%b data=%h want 0 0 0000 00", s_gv, s_wr, s_ready, s_data);
        end
    endtask

    task automatic test_single_burst();
        wr_t o, e;
        apply_reset();
        en = 4'b0100;
        push_beat(2, 'h11, 1'b0);
        push_beat(2, 'h22, 1'b0);
        push_beat(2, 'h33, 1'b1);
        drive();
        tick();
        checks++; if (s_gv !== 1'b0) begin errors++; $display("FAIL single_latency: got gv=%b want 0", s_gv); end
        tick();
        checks++; if (s_gv !== 1'b1 || s_gid !== 2'd2) begin
            errors++; $display("FAIL single_grant: got gv=%b id=%0d want 1 2", s_gv, s_gid);
        end
        for (int t = 0; t < 6; t++) tick();
        checks++; if (s_gv !== 1'b0) begin errors++; $display("FAIL single_release: got gv=%b want 0", s_gv); end
        checks++; if (obs_q.size() != 3) begin
            errors++; $display("FAIL single_count: got %0d writes want 3", obs_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                o = obs_q[k]; e = exp_q[k];
                checks++; if (o.id != e.id || o.data !== e.data || o.cyc != obs_q[0].cyc + k) begin
                    errors++;
                    $display("FAIL single_beat%0d: got id=%0d data=%h cyc=%0d want id=%0d data=%h cyc=%0d",
                             k, o.id, o.data, o.cyc, e.id, e.data, obs_q[0].cyc + k);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        wr_t o, e;
        int  prev;
        apply_reset();
        en = '1;
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 8; k++) begin
                beat_t b;
                b.data = DW'(i * 16 + k);
                b.last = 1'b0;
                prod_q[i].push_back(b);
            end
        for (int n = 0; n < 5; n++)
            for (int b = 0; b < MB; b++) begin
                e.id = n % NR; e.data = DW'((n % NR) * 16 + (n / NR) * MB + b); e.cyc = 0;
                exp_q.push_back(e);
            end
        drive();
        for (int t = 0; t < 60 && obs_q.size() < 20; t++) tick();
        checks++; if (obs_q.size() < 20) begin
            errors++; $display("FAIL rr_timeout: got %0d writes want 20", obs_q.size());
        end else begin
            prev = 0;
            for (int k = 0; k < 20; k++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                checks++; if (o.id != e.id || o.data !== e.data) begin
                    errors++; $display("FAIL rr_beat%0d: got id=%0d data=%h want id=%0d data=%h", k, o.id, o.data, e.id, e.data);
                end
                if (k > 0) begin
                    checks++; if (o.cyc - prev != ((k % MB == 0) ? 2 : 1)) begin
                        errors++; $display("FAIL rr_gap%0d: got %0d want %0d", k, o.cyc - prev, (k % MB == 0) ? 2 : 1);
                    end
                end
                prev = o.cyc;
            end
        end
    endtask

    task automatic test_full_stall();
        wr_t o, e;
        int  prev;
        apply_reset();
        en = 4'b0001;
        for (int k = 0; k < 4; k++) push_beat(0, 'hA0 + k, k == 3);
        drive();
        for (int t = 0; t < 10 && obs_q.size() < 2; t++) tick();
        force_full = 1'b1;
        drive();
        for (int t = 0; t < 10; t++) begin
            tick();
            checks++; if (s_wr !== 1'b0 || s_ready !== 4'b0 || s_gv !== 1'b1 || s_gid !== 2'd0) begin
                errors++;
                $display("FAIL stall_c%0d: got wr=%b rdy=%b gv=%b id=%0d want 0 0000 1 0", t, s_wr, s_ready, s_gv, s_gid);
            end
        end
        force_full = 1'b0;
        drive();
        for (int t = 0; t < 10 && obs_q.size() < 4; t++) tick();
        checks++; if (obs_q.size() != 4) begin
            errors++; $display("FAIL stall_count: got %0d writes want 4", obs_q.size());
        end else begin
            prev = 0;
            for (int k = 0; k < 4; k++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                checks++; if (o.id != e.id || o.data !== e.data) begin
                    errors++; $display("FAIL stall_beat%0d: got id=%0d data=%h want id=%0d data=%h", k, o.id, o.data, e.id, e.data);
                end
                if (k > 0) begin
                    checks++; if (o.cyc - prev != ((k == 2) ? 11 : 1)) begin
                        errors++; $display("FAIL stall_gap%0d: got %0d want %0d", k, o.cyc - prev, (k == 2) ? 11 : 1);
                    end
                end
                prev = o.cyc;
            end
        end
    endtask

    task automatic test_timeout();
        wr_t o0, o1;
        apply_reset();
        en = 4'b1010;
        push_beat(1, 'h51, 1'b0);
        push_beat(3, 'h73, 1'b1);
        drive();
        for (int t = 0; t < 10 && obs_q.size() < 1; t++) tick();
        for (int t = 0; t < HT; t++) begin
            tick();
            checks++; if (s_gv !== 1'b1 || s_gid !== 2'd1 || s_ready !== 4'b0010 || s_wr !== 1'b0) begin
                errors++;
                $display("FAIL hold_c%0d: got gv=%b id=%0d rdy=%b wr=%b want 1 1 0010 0", t, s_gv, s_gid, s_ready, s_wr);
            end
        end
        tick();
        checks++; if (s_gv !== 1'b0) begin errors++; $display("FAIL timeout_release: got gv=%b want 0", s_gv); end
        for (int t = 0; t < 10 && obs_q.size() < 2; t++) tick();
        checks++; if (obs_q.size() != 2) begin
            errors++; $display("FAIL timeout_count: got %0d writes want 2", obs_q.size());
        end else begin
            o0 = obs_q[0]; o1 = obs_q[1];
            checks++; if (o0.id != 1 || o0.data !== 8'h51 || o1.id != 3 || o1.data !== 8'h73) begin
                errors++; $display("FAIL timeout_order: got %0d/%h %0d/%h want 1/51 3/73", o0.id, o0.data, o1.id, o1.data);
            end
            checks++; if (o1.cyc - o0.cyc != HT + 2) begin
                errors++; $display("FAIL timeout_gap: got %0d want %0d", o1.cyc - o0.cyc, HT + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_t o, e;
        int  prev;
        apply_reset();
        en = 4'b0001;
        for (int k = 0; k < 8; k++) push_beat(0, 'hC0 + k, 1'b0);
        drive();
        for (int t = 0; t < 30 && obs_q.size() < 8; t++) tick();
        checks++; if (obs_q.size() != 8) begin
            errors++; $display("FAIL b2b_count: got %0d writes want 8", obs_q.size());
        end else begin
            prev = 0;
            for (int k = 0; k < 8; k++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                checks++; if (o.id != 0 || o.data !== e.data) begin
                    errors++; $display("FAIL b2b_beat%0d: got id=%0d data=%h want id=0 data=%h", k, o.id, o.data, e.data);
                end
                if (k > 0) begin
                    checks++; if (o.cyc - prev != ((k == 4) ? 2 : 1)) begin
                        errors++; $display("FAIL b2b_gap%0d: got %0d want %0d", k, o.cyc - prev, (k == 4) ? 2 : 1);
                    end
                end
                prev = o.cyc;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        wr_t o;
        apply_reset();
        en = 4'b0100;
        for (int k = 0; k < 4; k++) push_beat(2, 'h20 + k, 1'b0);
        drive();
        for (int t = 0; t < 10 && obs_q.size() < 1; t++) tick();
        #2 wr_rst_n = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0 ||
                      fifo_wr_en !== 1'b0 || fifo_data_in !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs: got gv=%b id=%0d rdy=%b wr=%b data=%h want all 0",
                     grant_valid, grant_id, req_ready, fifo_wr_en, fifo_data_in);
        end
        for (int i = 0; i < NR; i++) prod_q[i].delete();
        exp_q.delete();
        obs_q.delete();
        en = 4'b0101;
        push_beat(0, 'h0F, 1'b1);
        push_beat(2, 'h2F, 1'b1);
        drive();
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        @(posedge wr_clk);
        #1;
        cyc = 0;
        for (int t = 0; t < 10 && obs_q.size() < 1; t++) tick();
        checks++; if (obs_q.size() < 1) begin
            errors++; $display("FAIL midrst_timeout: got 0 writes want 1");
        end else begin
            o = obs_q[0];
            checks++; if (o.id != 0 || o.data !== 8'h0F) begin
                errors++; $display("FAIL midrst_first: got id=%0d data=%h want id=0 data=0f", o.id, o.data);
            end
        end
    endtask

    task automatic test_fifo_stream();
        int            nrd;
        int            nviol;
        int            id;
        logic [DW-1:0] d;
        apply_reset();
        model_en = 1'b1;
        en = 4'b0111;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 20; k++) begin
                beat_t b;
                b.data = DW'(i * 32 + k);
                b.last = (i == 0) ? (k % 3 == 2) : ((i == 1) ? (k == 19) : 1'b0);
                prod_q[i].push_back(b);
                exp_rq[i].push_back(DW'(i * 32 + k));
            end
        drive();
        nrd   = 0;
        nviol = 0;
        for (int t = 0; t < 3000 && nrd < 60; t++) begin
            tick();
            if (s_wr) begin
                checks++;
                if (s_full) begin
                    errors++; nviol++;
                    if (nviol < 4) $display("FAIL stream_full_write: got wr_en=1 with full=1 at cyc %0d", cyc);
                end
            end
            while (rd_q.size() > 0) begin
                d  = rd_q.pop_front();
                id = int'(d >> 5);
                nrd++;
                checks++;
                if (id > 2 || exp_rq[id].size() == 0 || exp_rq[id][0] !== d) begin
                    errors++; $display("FAIL stream_word%0d: got %h want next word of requester %0d", nrd, d, id);
                end else begin
                    void'(exp_rq[id].pop_front());
                end
            end
        end
        checks++; if (nrd != 60 || exp_rq[0].size() != 0 || exp_rq[1].size() != 0 || exp_rq[2].size() != 0) begin
            errors++;
            $display("FAIL stream_total: got %0d reads, left %0d/%0d/%0d want 60 reads, 0/0/0",
                     nrd, exp_rq[0].size(), exp_rq[1].size(), exp_rq[2].size());
        end
    endtask

    initial begin
        cyc = 0;
        en = '0;
        model_en = 1'b0;
        force_full = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid_burst();
        test_fifo_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
